// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller slice.
// No logic; imported by the controller and its lane datapath.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_WORDS  = 128;
  localparam int DMEM_IDX_W  = $clog2(DMEM_WORDS);

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    size_e                  size;
    logic                   uns;
    logic [63:0]            wdata;
  } req_t;

  function automatic logic misaligned(input logic [2:0] lo, input size_e sz);
    case (sz)
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      SZ_D:    return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane datapath: load extract/extend and store merge into a dword.
// Purely combinational, zero latency, no flow control.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [63:0] rd_dword,
  input  logic [2:0]  byte_off,
  input  size_e       size,
  input  logic        uns,
  input  logic [63:0] wdata,
  output logic [63:0] load_dat,
  output logic [63:0] merge_dat
);

  logic [63:0] shifted;
  logic [63:0] wdata_sh;
  logic [63:0] lane_mask;
  logic [7:0]  byte_en;
  logic        sgn;

  always_comb begin
    shifted = rd_dword >> {byte_off, 3'b000};
    sgn     = 1'b0;
    case (size)
      SZ_B: begin
        sgn      = ~uns & shifted[7];
        load_dat = {{56{sgn}}, shifted[7:0]};
      end
      SZ_H: begin
        sgn      = ~uns & shifted[15];
        load_dat = {{48{sgn}}, shifted[15:0]};
      end
      SZ_W: begin
        sgn      = ~uns & shifted[31];
        load_dat = {{32{sgn}}, shifted[31:0]};
      end
      default: load_dat = shifted;
    endcase
  end

  // Byte enables are built at offset 0 and slid into place; little-endian.
  always_comb begin
    case (size)
      SZ_B:    byte_en = 8'h01;
      SZ_H:    byte_en = 8'h03;
      SZ_W:    byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
    byte_en  = byte_en << byte_off;
    wdata_sh = wdata << {byte_off, 3'b000};
    lane_mask = '0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{byte_en[i]}};
    end
    merge_dat = (rd_dword & ~lane_mask) | (wdata_sh & lane_mask);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Arbitrates ports C/L onto one dword memory; load/dword store 2 cycles, sub-dword store 3, misaligned 1.
// One request in flight; ack only in IDLE, so a losing or late requester holds req until acked.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int MEM_DEPTH = DMEM_WORDS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         c_req,
  output logic                         c_ack,
  input  logic                         c_we,
  input  logic [ADDR_W-1:0]            c_addr,
  input  logic [1:0]                   c_size,
  input  logic                         c_uns,
  input  logic [63:0]                  c_wdata,
  output logic                         c_done,
  output logic                         c_err,
  output logic [63:0]                  c_rdata,
  input  logic                         l_req,
  output logic                         l_ack,
  input  logic                         l_we,
  input  logic [ADDR_W-1:0]            l_addr,
  input  logic [1:0]                   l_size,
  input  logic                         l_uns,
  input  logic [63:0]                  l_wdata,
  output logic                         l_done,
  output logic                         l_err,
  output logic [63:0]                  l_rdata,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [63:0]                  mem_wdata,
  input  logic [63:0]                  mem_rdata
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_e      state, state_nx;
  req_t        cur_q, in_req;
  logic        own_q;
  logic        last_l_q;
  logic        err_q;
  logic [63:0] buf_q;

  logic        c_win, l_win, accept, in_mis;
  logic [63:0] lane_rd, load_dat, merge_dat;

  // last_l_q resets high so C wins the first contention.
  assign c_win  = c_req && (!l_req || last_l_q);
  assign l_win  = l_req && (!c_req || !last_l_q);
  assign c_ack  = !reset && (state == ST_IDLE) && c_win;
  assign l_ack  = !reset && (state == ST_IDLE) && l_win;
  assign accept = c_ack || l_ack;

  always_comb begin
    in_req = '0;
    if (l_win) begin
      in_req.we    = l_we;
      in_req.addr  = l_addr;
      in_req.size  = size_e'(l_size);
      in_req.uns   = l_uns;
      in_req.wdata = l_wdata;
    end else begin
      in_req.we    = c_we;
      in_req.addr  = c_addr;
      in_req.size  = size_e'(c_size);
      in_req.uns   = c_uns;
      in_req.wdata = c_wdata;
    end
    in_mis = misaligned(in_req.addr[2:0], in_req.size);
  end

  // The lane sees live memory data in READ and the captured dword in WRITE.
  assign lane_rd = (state == ST_READ) ? mem_rdata : buf_q;

  dmem_lane u_lane (
    .rd_dword  (lane_rd),
    .byte_off  (cur_q.addr[2:0]),
    .size      (cur_q.size),
    .uns       (cur_q.uns),
    .wdata     (cur_q.wdata),
    .load_dat  (load_dat),
    .merge_dat (merge_dat)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    c_done    = 1'b0;
    l_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (in_mis)                             state_nx = ST_RESP;
          else if (in_req.we && in_req.size == SZ_D) state_nx = ST_WRITE;
          else                                    state_nx = ST_READ;
        end
      end
      ST_READ: begin
        mem_read = !reset;
        mem_addr = cur_q.addr[3 +: AW];
        state_nx = cur_q.we ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_write = !reset;
        mem_addr  = cur_q.addr[3 +: AW];
        mem_wdata = merge_dat;
        state_nx  = ST_RESP;
      end
      default: begin
        c_done   = !reset && !own_q;
        l_done   = !reset && own_q;
        state_nx = ST_IDLE;
      end
    endcase
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  assign c_err = c_done && err_q;
  assign l_err = l_done && err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q    <= '0;
      own_q    <= 1'b0;
      last_l_q <= 1'b1;
      err_q    <= 1'b0;
      buf_q    <= '0;
      c_rdata  <= '0;
      l_rdata  <= '0;
    end else begin
      if (accept) begin
        cur_q    <= in_req;
        own_q    <= l_ack;
        last_l_q <= l_ack;
        err_q    <= in_mis;
      end
      if (state == ST_READ) begin
        buf_q <= mem_rdata;
        if (!cur_q.we) begin
          if (own_q) l_rdata <= load_dat;
          else       c_rdata <= load_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: bench-side memory, byte-array reference model, directed + random requests.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_ack, c_we, c_uns, c_done, c_err;
  logic [9:0]  c_addr;
  logic [1:0]  c_size;
  logic [63:0] c_wdata, c_rdata;
  logic        l_req, l_ack, l_we, l_uns, l_done, l_err;
  logic [9:0]  l_addr;
  logic [1:0]  l_size;
  logic [63:0] l_wdata, l_rdata;
  logic        mem_read, mem_write;
  logic [6:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(10), .MEM_DEPTH(128)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_ack(c_ack), .c_we(c_we), .c_addr(c_addr), .c_size(c_size),
    .c_uns(c_uns), .c_wdata(c_wdata), .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
    .l_req(l_req), .l_ack(l_ack), .l_we(l_we), .l_addr(l_addr), .l_size(l_size),
    .l_uns(l_uns), .l_wdata(l_wdata), .l_done(l_done), .l_err(l_err), .l_rdata(l_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Bench-side physical memory.
  logic        mem_init;
  logic [63:0] env_mem [0:127];
  assign mem_rdata = env_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) env_mem[i] <= '0;
    end else if (mem_write) begin
      env_mem[mem_addr] <= mem_wdata;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [7:0]  ref_b [0:1023];
  logic [63:0] exp_rd [0:1];
  logic [63:0] last_wdat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [9:0] a, input logic [1:0] sz, input bit uns);
    int n = 1 << sz;
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_b[int'(a) + i]) << (8 * i));
    if (!uns && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8 * n));
    return v;
  endfunction

  function automatic logic [63:0] ref_dword(input int idx);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_b[idx*8 + i];
    return v;
  endfunction

  task automatic op(input bit p, input bit we, input logic [9:0] a, input logic [1:0] sz,
                    input bit uns, input logic [63:0] wd);
    int          n = 1 << sz;
    bit          mis = (int'(a) % n) != 0;
    int          lat;
    int          w = 0;
    bit          acked = 0, got = 0, saw_rd = 0, saw_wr = 0;
    logic [63:0] exp_ld, exp_wd;
    lat    = mis ? 1 : (!we ? 2 : (sz == 2'd3 ? 2 : 3));
    exp_ld = ref_load(a, sz, uns);
    exp_wd = ref_dword(int'(a[9:3]));
    if (!mis) for (int i = 0; i < n; i++) exp_wd[8*(int'(a[2:0]) + i) +: 8] = wd[8*i +: 8];
    @(posedge clk); #1;
    if (!p) begin
      c_we = we; c_addr = a; c_size = sz; c_uns = uns; c_wdata = wd; c_req = 1'b1;
    end else begin
      l_we = we; l_addr = a; l_size = sz; l_uns = uns; l_wdata = wd; l_req = 1'b1;
    end
    while (w < 8 && !acked) begin
      @(negedge clk);
      acked = p ? l_ack : c_ack;
      w++;
    end
    chk("ack", 64'(acked), 64'd1);
    @(posedge clk); #1;
    c_req = 1'b0;
    l_req = 1'b0;
    for (int cyc = 1; cyc <= 6 && !got; cyc++) begin
      @(negedge clk);
      if (mem_read) saw_rd = 1;
      if (mem_write) begin
        saw_wr    = 1;
        last_wdat = mem_wdata;
        chk("wr_addr", 64'(mem_addr), 64'(a[9:3]));
        chk("wr_dat", mem_wdata, exp_wd);
      end
      chk("other_done", 64'(p ? c_done : l_done), 64'd0);
      if (p ? l_done : c_done) begin
        got = 1;
        if (!we && !mis) exp_rd[p] = exp_ld;
        chk("latency", 64'(cyc), 64'(lat));
        chk("err", 64'(p ? l_err : c_err), 64'(mis));
        chk("rdata", p ? l_rdata : c_rdata, exp_rd[p]);
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("rd_seen", 64'(saw_rd), 64'(!mis && !(we && sz == 2'd3)));
    chk("wr_seen", 64'(saw_wr), 64'(!mis && we));
    if (we && !mis) for (int i = 0; i < n; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
  endtask

  initial begin
    bit          hit, p, we, uns;
    int          w, nc, nl, k, nd, owner, cyc, n;
    logic [1:0]  sz;
    logic [9:0]  a;
    logic [63:0] exp_c, exp_l;

    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_wdat = '0;
    reset = 1'b1; mem_init = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_size = '0; c_uns = 1'b0; c_wdata = '0;
    l_req = 1'b1; l_we = 1'b0; l_addr = '0; l_size = '0; l_uns = 1'b0; l_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_c_ack", 64'(c_ack), 0);
    chk("rst_l_ack", 64'(l_ack), 0);
    chk("rst_mem_read", 64'(mem_read), 0);
    chk("rst_mem_write", 64'(mem_write), 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_done", 64'({c_done, l_done, c_err, l_err}), 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_init = 1'b0; c_req = 1'b0; l_req = 1'b0;

    // Directed scenarios.
    op(0, 1, 10'h010, 2'd3, 0, 64'h1122334455667788);
    op(0, 0, 10'h010, 2'd3, 0, 64'h0);
    chk("dword_load", c_rdata, 64'h1122334455667788);
    op(0, 1, 10'h013, 2'd0, 0, 64'hAB);
    chk("rmw_wdat", last_wdat, 64'h11223344AB667788);
    op(0, 0, 10'h016, 2'd1, 1, 64'h0);
    chk("half_uns", c_rdata, 64'h0000000000001122);
    op(0, 0, 10'h013, 2'd0, 0, 64'h0);
    chk("byte_sext", c_rdata, 64'hFFFFFFFFFFFFFFAB);
    op(0, 0, 10'h012, 2'd2, 0, 64'h0);
    chk("mis_keep", c_rdata, 64'hFFFFFFFFFFFFFFAB);
    op(1, 1, 10'h020, 2'd2, 0, 64'hDEADBEEF_CAFEF00D);

    // Random traffic over a small window so accesses overlap.
    repeat (60) begin
      p   = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      n   = 1 << sz;
      a   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 47));
      if ($urandom_range(0, 2) != 0) a = a & ~10'(n - 1);
      op(p, we, a, sz, uns, {$urandom, $urandom});
    end

    // Reset during the WRITE cycle of a sub-dword store.
    @(posedge clk); #1;
    c_we = 1'b1; c_addr = 10'h021; c_size = 2'd0; c_uns = 1'b0; c_wdata = 64'h5A; c_req = 1'b1;
    w = 0; hit = 0;
    while (w < 8 && !hit) begin @(negedge clk); hit = c_ack; w++; end
    chk("rst_op_ack", 64'(hit), 1);
    @(posedge clk); #1;
    c_req = 1'b0;
    w = 0; hit = 0;
    while (w < 6 && !hit) begin @(negedge clk); hit = mem_write; w++; end
    chk("rst_reach_wr", 64'(hit), 1);
    reset = 1'b1;
    #1;
    chk("rst_gate_wr", 64'(mem_write), 0);
    chk("rst_no_done", 64'(c_done), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst2_outs", 64'({c_ack, l_ack, c_done, l_done, c_err, l_err, mem_read, mem_write}), 0);
    chk("rst2_maddr", 64'(mem_addr), 0);
    chk("rst2_mwdat", mem_wdata, 0);
    chk("rst2_crd", c_rdata, 0);
    chk("rst2_lrd", l_rdata, 0);
    chk("rst_mem_kept", env_mem[4], ref_dword(4));
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin @(negedge clk); chk("rst_dropped", 64'(c_done), 0); end

    // Contention: both ports keep requesting; grants alternate starting with C.
    exp_c = ref_load(10'h010, 2'd3, 0);
    exp_l = ref_load(10'h018, 2'd2, 1);
    @(posedge clk); #1;
    c_we = 1'b0; c_addr = 10'h010; c_size = 2'd3; c_uns = 1'b0;
    l_we = 1'b0; l_addr = 10'h018; l_size = 2'd2; l_uns = 1'b1;
    c_req = 1'b1; l_req = 1'b1;
    nc = 0; nl = 0; k = 0; nd = 0; owner = 0; cyc = 0;
    while (nd < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (c_ack || l_ack) begin
        chk("one_ack", 64'(c_ack && l_ack), 0);
        chk("ack_order", 64'(l_ack), 64'(k % 2));
        owner = int'(l_ack);
        k++;
        if (l_ack) nl++; else nc++;
      end
      if (c_done) begin
        chk("c_owner", 64'(owner), 0);
        chk("c_cont_rd", c_rdata, exp_c);
        nd++;
      end
      if (l_done) begin
        chk("l_owner", 64'(owner), 1);
        chk("l_cont_rd", l_rdata, exp_l);
        nd++;
      end
      @(posedge clk); #1;
      if (nc == 3) c_req = 1'b0;
      if (nl == 3) l_req = 1'b0;
    end
    c_req = 1'b0; l_req = 1'b0;
    chk("cont_acks", 64'(k), 6);
    chk("cont_dones", 64'(nd), 6);
    exp_rd[0] = exp_c;
    exp_rd[1] = exp_l;

    op(0, 0, 10'h021, 2'd0, 1, 64'h0);
    op(1, 0, 10'h020, 2'd3, 0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
